bits_apb_host: RTL

//  APB3 initiator that runs one complete BITS decode job against the BITS register

---
 rtl/bits_apb_host_if.sv | 40 ++++
 rtl/bits_apb_host.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bits_apb_host_if.sv
// bits_apb_host_if: bundles the BITS job command/response channels and the APB3 bus.
// Latency: none, wires only.
// Backpressure: carries cmd_valid/cmd_ready, rsp_valid/rsp_ready and APB pready unchanged.
//
// Modports: master = the host block (drives cmd_ready, rsp_*, busy, APB requests);
//           slave  = its environment (command source, result sink, APB completer).
interface bits_apb_host_if;
  // Job command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_bytes;
  // Job response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_version_sum;
  logic [63:0] rsp_value;
  logic        rsp_error;
  logic        busy;
  // APB3 initiator
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [5:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    input  cmd_valid, cmd_bytes, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_version_sum, rsp_value, rsp_error, busy,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_bytes, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_version_sum, rsp_value, rsp_error, busy,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/bits_apb_host.sv
// bits_apb_host: APB3 initiator running one BITS decode job (write length, start, poll done, read results).
// Latency: 13 cycles accept -> rsp_valid minimum (pready=1, done on first poll); each extra poll adds POLL_GAP+2.
// Backpressure: one job at a time (cmd_ready only while idle); results held on rsp_* until rsp_ready.
//
// Ports: clk; resetB (asynchronous, active-low); bus (bits_apb_host_if.master) carrying the
//   cmd_valid/cmd_ready/cmd_bytes request, rsp_valid/rsp_ready/rsp_* result, busy, and the APB3
//   initiator signals psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr.
// Build option: define BITS_HOST_TIMEOUT_EN to abort a job with rsp_error after TIMEOUT_POLLS
//   polls that did not see done; without it the host polls until done appears.
module bits_apb_host #(
  parameter int POLL_GAP      = 4,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic            clk,
  input  logic            resetB,
  bits_apb_host_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_LEN,
    ST_WR_START,
    ST_POLL,
    ST_GAP,
    ST_RD_VSUM,
    ST_RD_HI,
    ST_RD_LO,
    ST_RESP
  } state_e;

  // BITS register word addresses
  localparam logic [5:0] A_CTRL = 6'h00;  // write bit0 = start, read bit8 = done
  localparam logic [5:0] A_LEN  = 6'h01;
  localparam logic [5:0] A_VSUM = 6'h02;
  localparam logic [5:0] A_HI   = 6'h04;
  localparam logic [5:0] A_LO   = 6'h05;

  // Gap counter is loaded with the last index and counts down to zero.
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_e      state_q,  state_d;
  logic        access_q, access_d;   // 0 = SETUP sub-phase, 1 = ACCESS sub-phase
  logic [15:0] bytes_q,  bytes_d;
  logic [15:0] vsum_q,   vsum_d;
  logic [63:0] value_q,  value_d;
  logic        err_q,    err_d;
  logic [15:0] gap_q,    gap_d;

`ifdef BITS_HOST_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_POLLS);
  logic [15:0] polls_q, polls_d;     // completed polls that returned done=0
`else
  // The watchdog bound only matters when the timeout logic is built in.
  if (TIMEOUT_POLLS < 0) begin : g_timeout_unused
  end
`endif

  logic        apb_st;
  logic        timed_out;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [5:0]  paddr;
  logic [31:0] pwdata;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state_q  <= ST_IDLE;
      access_q <= 1'b0;
      bytes_q  <= '0;
      vsum_q   <= '0;
      value_q  <= '0;
      err_q    <= 1'b0;
      gap_q    <= '0;
`ifdef BITS_HOST_TIMEOUT_EN
      polls_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
      bytes_q  <= bytes_d;
      vsum_q   <= vsum_d;
      value_q  <= value_d;
      err_q    <= err_d;
      gap_q    <= gap_d;
`ifdef BITS_HOST_TIMEOUT_EN
      polls_q  <= polls_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    access_d  = access_q;
    bytes_d   = bytes_q;
    vsum_d    = vsum_q;
    value_d   = value_q;
    err_d     = err_q;
    gap_d     = gap_q;
    timed_out = 1'b0;
`ifdef BITS_HOST_TIMEOUT_EN
    polls_d   = polls_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          // New job: results from the previous job are discarded here.
          bytes_d  = bus.cmd_bytes;
          vsum_d   = '0;
          value_d  = '0;
          err_d    = 1'b0;
          access_d = 1'b0;
`ifdef BITS_HOST_TIMEOUT_EN
          polls_d  = '0;
`endif
          state_d  = ST_WR_LEN;
        end
      end

      ST_GAP: begin
        if (gap_q == 16'd0) begin
          state_d = ST_POLL;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_LEN, ST_WR_START, ST_POLL, ST_RD_VSUM, ST_RD_HI, ST_RD_LO: begin
        if (!access_q) begin
          access_d = 1'b1;
        end else if (bus.pready) begin
          // Transfer completes; the next SETUP (if any) starts next cycle.
          access_d = 1'b0;
          if (bus.pslverr) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            case (state_q)
              ST_WR_LEN:   state_d = ST_WR_START;
              ST_WR_START: state_d = ST_POLL;
              ST_POLL: begin
                if (bus.prdata[8]) begin
                  state_d = ST_RD_VSUM;
                end else begin
`ifdef BITS_HOST_TIMEOUT_EN
                  polls_d   = polls_q + 16'd1;
                  timed_out = (polls_d == TO_LIMIT);
`endif
                  if (timed_out) begin
                    err_d   = 1'b1;
                    vsum_d  = '0;
                    value_d = '0;
                    state_d = ST_RESP;
                  end else if (POLL_GAP == 0) begin
                    state_d = ST_POLL;
                  end else begin
                    gap_d   = GAP_LAST;
                    state_d = ST_GAP;
                  end
                end
              end
              ST_RD_VSUM: begin
                vsum_d  = bus.prdata[15:0];
                state_d = ST_RD_HI;
              end
              ST_RD_HI: begin
                value_d[63:32] = bus.prdata;
                state_d        = ST_RD_LO;
              end
              ST_RD_LO: begin
                value_d[31:0] = bus.prdata;
                state_d       = ST_RESP;
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end

      default: begin
        access_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // APB request decode: everything is zero outside a transfer, and address,
  // direction and write data depend on state only, so they stay stable from
  // SETUP through the end of ACCESS.
  // ---------------------------------------------------------------------------
  always_comb begin
    apb_st  = (state_q == ST_WR_LEN)  || (state_q == ST_WR_START) ||
              (state_q == ST_POLL)    || (state_q == ST_RD_VSUM)  ||
              (state_q == ST_RD_HI)   || (state_q == ST_RD_LO);
    psel    = apb_st;
    penable = apb_st && access_q;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    case (state_q)
      ST_WR_LEN: begin
        pwrite = 1'b1;
        paddr  = A_LEN;
        pwdata = {16'h0000, bytes_q};
      end
      ST_WR_START: begin
        pwrite = 1'b1;
        paddr  = A_CTRL;
        pwdata = 32'h0000_0001;
      end
      ST_POLL:    paddr = A_CTRL;
      ST_RD_VSUM: paddr = A_VSUM;
      ST_RD_HI:   paddr = A_HI;
      ST_RD_LO:   paddr = A_LO;
      default: begin
        pwrite = 1'b0;
        paddr  = '0;
      end
    endcase
  end

  assign bus.psel            = psel;
  assign bus.penable         = penable;
  assign bus.pwrite          = pwrite;
  assign bus.paddr           = paddr;
  assign bus.pwdata          = pwdata;

  assign bus.cmd_ready       = (state_q == ST_IDLE);
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.rsp_valid       = (state_q == ST_RESP);
  assign bus.rsp_version_sum = vsum_q;
  assign bus.rsp_value       = value_q;
  assign bus.rsp_error       = err_q;

endmodule
